// File: rtl/data_mem_responder_if.sv
// CPU data-side memory bus: level requests from the controller, registered
// completion status and read data back from the responder.
interface data_mem_responder_if;
  logic [31:0] address_data;
  logic [31:0] data_in;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] data_out;
  logic        mem_ready;
  logic        mem_fault;

  modport master (
    output address_data, data_in, MemWrite, MemRead,
    input  data_out, mem_ready, mem_fault
  );

  modport slave (
    input  address_data, data_in, MemWrite, MemRead,
    output data_out, mem_ready, mem_fault
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM with programmable read latency and a 4-phase mem_ready handshake.
// Defining MEM_LED_EN maps a one-bit LED register at LED_ADDR in front of the RAM decode.
module data_mem_responder #(
  parameter int          DEPTH_WORDS  = 256,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] LED_ADDR     = 32'hFFFF_FFF0
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus,
  output logic                led
);
  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t state, state_next;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [31:0]   offset;
  logic [AW-1:0] cur_idx, idx_q, rd_idx;
  logic [3:0]    cnt;
  logic [31:0]   rd_data, data_q;
  logic          ready_q, fault_q;
  logic          any_req, rd_req, wr_req, legal, led_hit, led_rd_sel;
  logic          req_fault, accept, load_rd, ram_we;

  assign offset    = bus.address_data - BASE_ADDR;
  assign cur_idx   = offset[AW+1:2];
  assign legal     = (offset[1:0] == 2'b00) && ((offset >> (AW + 2)) == 32'd0);
  assign rd_req    = bus.MemRead & ~bus.MemWrite;
  assign wr_req    = bus.MemWrite & ~bus.MemRead;
  assign any_req   = bus.MemRead | bus.MemWrite;
  assign req_fault = (bus.MemRead & bus.MemWrite) | (any_req & ~legal & ~led_hit);
  assign accept    = (state == IDLE) && any_req;
  assign ram_we    = accept && wr_req && !req_fault && !led_hit;

  // A read that completes straight from IDLE uses the live index; one leaving BUSY uses the latched one.
  assign rd_idx  = (state == IDLE) ? cur_idx : idx_q;
  assign rd_data = led_rd_sel ? {31'b0, led} : ram[rd_idx];

  always_comb begin
    state_next = state;
    load_rd    = 1'b0;
    case (state)
      IDLE: if (any_req) begin
        if (rd_req && !req_fault && LAT_M1 != 4'd0) begin
          state_next = BUSY;
        end else begin
          state_next = ACK;
          load_rd    = rd_req && !req_fault;
        end
      end
      BUSY: if (cnt == 4'd1) begin
        state_next = ACK;
        load_rd    = 1'b1;
      end
      ACK: if (!any_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      data_q  <= 32'd0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == ACK);
      if (accept) begin
        idx_q <= cur_idx;
        cnt   <= LAT_M1;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      if (state_next != ACK) fault_q <= 1'b0;
      else if (accept)       fault_q <= req_fault;
      // Faulted writes leave data_out alone; any other faulted request zeroes it.
      if (load_rd)                             data_q <= rd_data;
      else if (accept && req_fault && !wr_req) data_q <= 32'd0;
    end
  end

  // RAM has no reset so it maps onto block memory and survives a reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[cur_idx] <= bus.data_in;
  end

  assign bus.data_out  = data_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_fault = fault_q;

`ifdef MEM_LED_EN
  logic led_q, led_sel_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q     <= 1'b0;
      led_sel_q <= 1'b0;
    end else if (accept) begin
      led_sel_q <= led_hit;
      if (wr_req && led_hit) led_q <= bus.data_in[0];
    end
  end

  assign led_hit    = (bus.address_data == LED_ADDR);
  assign led_rd_sel = accept ? led_hit : led_sel_q;
  assign led        = led_q;
`else
  logic unused_led_addr;

  assign unused_led_addr = ^LED_ADDR;
  assign led_hit         = 1'b0;
  assign led_rd_sel      = 1'b0;
  assign led             = 1'b0;
`endif

endmodule
